// File: rtl/tchk_vec_driver.sv
// Launch side of the vector setup-check interface: derives a slow sample strobe
// from clk and launches queued vectors a programmable number of ticks before each rise.
module tchk_vec_driver #(
    parameter int WIDTH     = 8,
    parameter int HALF_PER  = 5,
    parameter int DEPTH     = 4,
    parameter int SETUP_MIN = 6,
    localparam int OW       = $clog2(2 * HALF_PER)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [OW-1:0]    launch_off,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sclk,
    output logic [WIDTH-1:0] out_data,
    output logic             out_new,
    output logic             underrun,
    output logic             setup_viol,
    output logic             viol_sticky
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OW-1:0] PH_LAST  = OW'(2 * HALF_PER - 1);
    localparam logic [OW-1:0] PH_HALF  = OW'(HALF_PER);
    localparam logic [OW-1:0] PH_3HALF = OW'(3 * HALF_PER);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [OW-1:0]    ph_q, ph_d;
    logic [OW-1:0]    off_q, off_d;
    logic [OW-1:0]    lp;
    logic             sclk_q, sclk_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_new_q, out_new_d;
    logic             underrun_q, underrun_d;
    logic             setup_viol_q, setup_viol_d;
    logic             viol_sticky_q, viol_sticky_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wrap, launch, push, pop, fifo_empty;

    assign in_ready   = (count_q < CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign wrap       = en && (ph_q == PH_LAST);

    // Launch point is (HALF_PER - off) mod 2*HALF_PER; offsets beyond a half
    // period land late in the preceding period.
    always_comb begin
        if (off_q <= PH_HALF) begin
            lp = PH_HALF - off_q;
        end else begin
            lp = PH_3HALF - off_q;
        end
    end

    always_comb begin
        ph_d = ph_q;
        if (en) begin
            ph_d = wrap ? '0 : ph_q + OW'(1);
        end
        off_d         = wrap ? launch_off : off_q;
        sclk_d        = (ph_d >= PH_HALF);
        launch        = en && (ph_d == lp);
        push          = in_valid && in_ready;
        pop           = launch && !fifo_empty;
        out_new_d     = pop;
        underrun_d    = launch && fifo_empty;
        setup_viol_d  = launch && (int'(off_q) < SETUP_MIN);
        viol_sticky_d = viol_sticky_q | setup_viol_q;
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q          <= '0;
            off_q         <= '0;
            sclk_q        <= 1'b0;
            out_data_q    <= '0;
            out_new_q     <= 1'b0;
            underrun_q    <= 1'b0;
            setup_viol_q  <= 1'b0;
            viol_sticky_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            ph_q          <= ph_d;
            off_q         <= off_d;
            sclk_q        <= sclk_d;
            out_new_q     <= out_new_d;
            underrun_q    <= underrun_d;
            setup_viol_q  <= setup_viol_d;
            viol_sticky_q <= viol_sticky_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (pop) begin
                out_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign sclk        = sclk_q;
    assign out_data    = out_data_q;
    assign out_new     = out_new_q;
    assign underrun    = underrun_q;
    assign setup_viol  = setup_viol_q;
    assign viol_sticky = viol_sticky_q;

endmodule
